if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req_o  output  1  instruction-memory request valid.
REQ-005 imem_addr_o  output  32  byte address of request.
REQ-006 imem_gnt_i  input  1  request accepted when imem_req_o && imem_gnt_i at an edge.
REQ-007 imem_rvalid_i  input  1  one response per accepted request, in order, no earlier than the cycle after grant.
REQ-008 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-009 stall_i  input  1  decode stage cannot accept; hold outputs.
REQ-010 flush_i  input  1  redirect fetch to new_pc_i.
REQ-011 new_pc_i  input  32  redirect target, word-aligned.
REQ-012 pc_o  output  32  PC of instruction presented to decode.
REQ-013 inst_o  output  32  instruction presented to decode (32'h0 = NOP).
REQ-014 valid_o  output  1  pc_o/inst_o hold a real instruction.

Function
REQ-015 Internal state: fetch_pc, rsp_pc, outstanding (0..2), drop_cnt (0..2), 2-entry FIFO of {pc, inst}, output register {pc_o, inst_o, valid_o}.
REQ-016 pop = !flush_i && !stall_i && FIFO non-empty.
REQ-017 imem_req_o = !flush_i && (outstanding + fifo_count - pop) < 2; never depends on imem_gnt_i.
REQ-018 imem_addr_o = fetch_pc; while imem_req_o high and imem_gnt_i low, imem_addr_o SHALL stay stable.
REQ-019 On accept: fetch_pc += 4 (modulo 2^32, wraps to 0), outstanding += 1.
REQ-020 outstanding_next = outstanding + accept - imem_rvalid_i, including responses being dropped.
REQ-021 Response with drop_cnt > 0: discarded, drop_cnt -= 1.
REQ-022 Response with drop_cnt == 0 and no flush: push {rsp_pc, imem_rdata_i} into FIFO, rsp_pc += 4.
REQ-023 Push and pop in same cycle SHALL be allowed; FIFO never overflows by REQ-017 (overflow is an assertion failure).
REQ-024 Output register priority per edge: flush_i > stall_i > pop > idle.
REQ-025 flush_i: pc_o, inst_o, valid_o <= 0; FIFO cleared; fetch_pc, rsp_pc <= new_pc_i; drop_cnt <= outstanding - imem_rvalid_i; no request issued that cycle.
REQ-026 stall_i (no flush): pc_o, inst_o, valid_o held; FIFO push still allowed.
REQ-027 pop: {pc_o, inst_o} <= FIFO head, valid_o <= 1.
REQ-028 Idle (no flush, no stall, FIFO empty): inst_o <= 0, pc_o <= 0, valid_o <= 0.
REQ-029 No response-to-output bypass: latency grant edge -> valid_o rising is 2 edges minimum.
REQ-030 Steady state with imem_gnt_i = 1 and 1-cycle response: one instruction per cycle, consecutive pc_o values differing by 4.
REQ-031 No instruction SHALL be lost or duplicated across any stall/flush sequence; flushed-path instructions never reach valid_o.

Reset
REQ-032 rst_n low asynchronously forces: imem_req_o = 0, pc_o = 0, inst_o = 0, valid_o = 0, outstanding = 0, drop_cnt = 0, FIFO empty, fetch_pc = rsp_pc = RESET_PC.
REQ-033 Responses to requests in flight when reset asserted SHALL be the memory's responsibility to cancel; block assumes none arrive after rst_n rises.
REQ-034 First request at RESET_PC SHALL be asserted in the first cycle after rst_n deasserts.

Verification
REQ-035 Release reset, gnt = 1, rdata = addr, rvalid 1 cycle after grant -> valid_o high 2 edges after first grant; pc_o/inst_o = 0,4,8,12 on consecutive cycles.
REQ-036 stall_i high 3 cycles mid-stream -> outputs held; imem_req_o drops when outstanding + fifo_count = 2; after release sequence continues with no gap in pc and no duplicate.
REQ-037 flush_i with new_pc_i = 32'h100 while 2 responses outstanding -> both discarded; next valid_o shows pc_o = 32'h100, inst_o = 32'h100.
REQ-038 imem_gnt_i low 5 cycles -> imem_req_o held, imem_addr_o stable; valid_o falls once FIFO drains; resumes correctly on grant.
REQ-039 rst_n pulsed low mid-stream (not on an edge) -> outputs 0 immediately; after release fetch restarts at RESET_PC.
REQ-040 flush_i and stall_i high same cycle, fetch_pc = 32'hFFFF_FFFC before flush -> flush wins (valid_o = 0, next pc_o = new_pc_i); separate run confirms fetch_pc wrap 32'hFFFF_FFFC -> 0.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: in-order imem requests, 2-entry response FIFO and a
// registered decode interface with stall/flush handling.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_if.master  imem,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic [1:0]   outstanding;
  logic [1:0]   drop_cnt;
  logic [1:0]   fifo_count;
  logic         rd_ptr;
  logic         wr_ptr;
  fetch_entry_t fifo_mem [2];

  logic         pop;
  logic         push;
  logic         accept;
  logic         drop_rsp;
  logic [2:0]   in_flight;

  // in_flight counts slots still claimed after this cycle's pop; a new request
  // only goes out if its response is guaranteed a FIFO slot.
  assign pop       = !flush_i && !stall_i && (fifo_count != 2'd0);
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count} - {2'b00, pop};
  assign imem.imem_req_o  = rst_n && !flush_i && (in_flight < 3'd2);
  assign imem.imem_addr_o = fetch_pc;
  assign accept    = imem.imem_req_o && imem.imem_gnt_i;
  assign drop_rsp  = imem.imem_rvalid_i && (drop_cnt != 2'd0);
  assign push      = imem.imem_rvalid_i && (drop_cnt == 2'd0) && !flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      fifo_count  <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, imem.imem_rvalid_i};
      if (flush_i) begin
        // Everything still in flight belongs to the abandoned path.
        fetch_pc   <= new_pc_i;
        rsp_pc     <= new_pc_i;
        drop_cnt   <= outstanding - {1'b0, imem.imem_rvalid_i};
        fifo_count <= 2'd0;
        rd_ptr     <= 1'b0;
        wr_ptr     <= 1'b0;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + 32'd4;
        if (drop_rsp) drop_cnt <= drop_cnt - 2'd1;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // NOTE: FIFO storage has no reset; fifo_count guarantees an entry is written before it is read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{pc: rsp_pc, inst: imem.imem_rdata_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o    <= 32'h0;
      inst_o  <= 32'h0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      pc_o    <= 32'h0;
      inst_o  <= 32'h0;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (pop) begin
        pc_o    <= fifo_mem[rd_ptr].pc;
        inst_o  <= fifo_mem[rd_ptr].inst;
        valid_o <= 1'b1;
      end else begin
        pc_o    <= 32'h0;
        inst_o  <= 32'h0;
        valid_o <= 1'b0;
      end
    end
  end

  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && !pop && (fifo_count == 2'd2))
  );

endmodule
